// File: rtl/rasterizer_triangle_setup.sv
// Triangle setup stage between vertex fetch and rasterizer traversal.
//
// Accepts one 15-word triangle record (3 vertices x {x, y, z, color, reserved}),
// computes one edge function per cycle (A, B, C), sums the C terms into twice
// the signed area, normalises winding so area2 > 0, culls degenerate and fully
// off-screen triangles, and emits a clamped inclusive bounding box.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   in_valid, vertex_in  upstream triangle record; stall_out backpressures upstream
//   done_in, done_out    end-of-stream handshake (done_out registered)
//   stall_in, out_valid  downstream backpressure / setup record valid
//   edge_a/b/c, area2    edge coefficients per edge 0..2 and 2x area
//   bbox_*               screen-clamped inclusive bounding box
//   z_out, color_out     per-vertex z and color passthrough
//   cull_count           culled triangles since reset (wraps)
module rasterizer_triangle_setup #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [14:0][31:0] vertex_in,
    output logic              stall_out,
    input  logic              done_in,
    output logic              done_out,
    input  logic              stall_in,
    output logic              out_valid,
    output logic [2:0][31:0]  edge_a,
    output logic [2:0][31:0]  edge_b,
    output logic [2:0][31:0]  edge_c,
    output logic [31:0]       area2,
    output logic [15:0]       bbox_min_x,
    output logic [15:0]       bbox_min_y,
    output logic [15:0]       bbox_max_x,
    output logic [15:0]       bbox_max_y,
    output logic [2:0][31:0]  z_out,
    output logic [2:0][31:0]  color_out,
    output logic [15:0]       cull_count
);

    typedef enum logic [2:0] {StIdle, StEdge0, StEdge1, StEdge2, StFinal, StOut} state_e;

    localparam logic signed [15:0] XMax = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] YMax = 16'(SCREEN_H - 1);

    state_e state_q, state_d;

    // Captured vertex data
    logic [2:0][15:0] vx_q, vx_d, vy_q, vy_d;
    logic [2:0][31:0] vz_q, vz_d, vc_q, vc_d;

    // Raw (pre-winding-normalisation) edge coefficients
    logic [2:0][31:0] ea_q, ea_d, eb_q, eb_d, ec_q, ec_d;

    // Raw bounding box accumulated over the edge cycles
    logic signed [15:0] bb_min_x_q, bb_min_x_d, bb_min_y_q, bb_min_y_d;
    logic signed [15:0] bb_max_x_q, bb_max_x_d, bb_max_y_q, bb_max_y_d;

    // Registered outputs
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic [15:0]       cull_q, cull_d;
    logic [2:0][31:0]  edge_a_q, edge_a_d, edge_b_q, edge_b_d, edge_c_q, edge_c_d;
    logic [31:0]       area2_q, area2_d;
    logic [15:0]       min_x_q, min_x_d, min_y_q, min_y_d, max_x_q, max_x_d, max_y_q, max_y_d;
    logic [2:0][31:0]  z_q, z_d, color_q, color_d;

    // Edge datapath: edge ei runs from vertex ei to vertex ej
    logic [1:0]         ei, ej;
    logic signed [15:0] xs, ys;
    logic signed [31:0] xi, yi, xj, yj, prod_ij, prod_ji;
    logic signed [31:0] area_raw;
    logic               area_neg, cull;

    always_comb begin
        case (state_q)
            StEdge1: begin ei = 2'd1; ej = 2'd2; end
            StEdge2: begin ei = 2'd2; ej = 2'd0; end
            default: begin ei = 2'd0; ej = 2'd1; end
        endcase
        xs = vx_q[ei];
        ys = vy_q[ei];
        xi = {{16{vx_q[ei][15]}}, vx_q[ei]};
        yi = {{16{vy_q[ei][15]}}, vy_q[ei]};
        xj = {{16{vx_q[ej][15]}}, vx_q[ej]};
        yj = {{16{vy_q[ej][15]}}, vy_q[ej]};
        prod_ij = xi * yj;
        prod_ji = xj * yi;
    end

    always_comb begin
        area_raw = ec_q[0] + ec_q[1] + ec_q[2];
        area_neg = area_raw[31];
        cull = (area_raw == 32'sd0) || (bb_max_x_q < 0) || (bb_min_x_q > XMax) ||
               (bb_max_y_q < 0) || (bb_min_y_q > YMax);
    end

    always_comb begin
        state_d     = state_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        vz_d        = vz_q;
        vc_d        = vc_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        ec_d        = ec_q;
        bb_min_x_d  = bb_min_x_q;
        bb_min_y_d  = bb_min_y_q;
        bb_max_x_d  = bb_max_x_q;
        bb_max_y_d  = bb_max_y_q;
        out_valid_d = out_valid_q;
        cull_d      = cull_q;
        edge_a_d    = edge_a_q;
        edge_b_d    = edge_b_q;
        edge_c_d    = edge_c_q;
        area2_d     = area2_q;
        min_x_d     = min_x_q;
        min_y_d     = min_y_q;
        max_x_d     = max_x_q;
        max_y_d     = max_y_q;
        z_d         = z_q;
        color_d     = color_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    for (int v = 0; v < 3; v++) begin
                        vx_d[v] = vertex_in[5*v][15:0];
                        vy_d[v] = vertex_in[5*v+1][15:0];
                        vz_d[v] = vertex_in[5*v+2];
                        vc_d[v] = vertex_in[5*v+3];
                    end
                    state_d = StEdge0;
                end
            end
            StEdge0, StEdge1, StEdge2: begin
                ea_d[ei] = yi - yj;
                eb_d[ei] = xj - xi;
                ec_d[ei] = prod_ij - prod_ji;
                // Vertex ei is folded into the box on its own edge cycle
                if (state_q == StEdge0) begin
                    bb_min_x_d = xs;
                    bb_max_x_d = xs;
                    bb_min_y_d = ys;
                    bb_max_y_d = ys;
                end else begin
                    if (xs < bb_min_x_q) bb_min_x_d = xs;
                    if (xs > bb_max_x_q) bb_max_x_d = xs;
                    if (ys < bb_min_y_q) bb_min_y_d = ys;
                    if (ys > bb_max_y_q) bb_max_y_d = ys;
                end
                case (state_q)
                    StEdge0: state_d = StEdge1;
                    StEdge1: state_d = StEdge2;
                    default: state_d = StFinal;
                endcase
            end
            StFinal: begin
                if (cull) begin
                    cull_d  = cull_q + 16'd1;
                    state_d = StIdle;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        edge_a_d[k] = area_neg ? -ea_q[k] : ea_q[k];
                        edge_b_d[k] = area_neg ? -eb_q[k] : eb_q[k];
                        edge_c_d[k] = area_neg ? -ec_q[k] : ec_q[k];
                    end
                    area2_d     = area_neg ? -area_raw : area_raw;
                    // Not culled, so each raw box overlaps the screen on both axes
                    min_x_d     = (bb_min_x_q < 0) ? 16'd0 : bb_min_x_q;
                    min_y_d     = (bb_min_y_q < 0) ? 16'd0 : bb_min_y_q;
                    max_x_d     = (bb_max_x_q > XMax) ? XMax : bb_max_x_q;
                    max_y_d     = (bb_max_y_q > YMax) ? YMax : bb_max_y_q;
                    z_d         = vz_q;
                    color_d     = vc_q;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end
            end
            StOut: begin
                if (!stall_in) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        done_d = done_in && (state_q == StIdle) && !in_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            vx_q        <= '0;
            vy_q        <= '0;
            vz_q        <= '0;
            vc_q        <= '0;
            ea_q        <= '0;
            eb_q        <= '0;
            ec_q        <= '0;
            bb_min_x_q  <= '0;
            bb_min_y_q  <= '0;
            bb_max_x_q  <= '0;
            bb_max_y_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cull_q      <= '0;
            edge_a_q    <= '0;
            edge_b_q    <= '0;
            edge_c_q    <= '0;
            area2_q     <= '0;
            min_x_q     <= '0;
            min_y_q     <= '0;
            max_x_q     <= '0;
            max_y_q     <= '0;
            z_q         <= '0;
            color_q     <= '0;
        end else begin
            state_q     <= state_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            vz_q        <= vz_d;
            vc_q        <= vc_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            ec_q        <= ec_d;
            bb_min_x_q  <= bb_min_x_d;
            bb_min_y_q  <= bb_min_y_d;
            bb_max_x_q  <= bb_max_x_d;
            bb_max_y_q  <= bb_max_y_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            cull_q      <= cull_d;
            edge_a_q    <= edge_a_d;
            edge_b_q    <= edge_b_d;
            edge_c_q    <= edge_c_d;
            area2_q     <= area2_d;
            min_x_q     <= min_x_d;
            min_y_q     <= min_y_d;
            max_x_q     <= max_x_d;
            max_y_q     <= max_y_d;
            z_q         <= z_d;
            color_q     <= color_d;
        end
    end

    assign stall_out  = (state_q != StIdle);
    assign out_valid  = out_valid_q;
    assign done_out   = done_q;
    assign cull_count = cull_q;
    assign edge_a     = edge_a_q;
    assign edge_b     = edge_b_q;
    assign edge_c     = edge_c_q;
    assign area2      = area2_q;
    assign bbox_min_x = min_x_q;
    assign bbox_min_y = min_y_q;
    assign bbox_max_x = max_x_q;
    assign bbox_max_y = max_y_q;
    assign z_out      = z_q;
    assign color_out  = color_q;

    // Upper halves of the x/y words and the reserved words carry no information
    logic unused_bits;
    assign unused_bits = ^{vertex_in[0][31:16], vertex_in[1][31:16], vertex_in[4],
                           vertex_in[5][31:16], vertex_in[6][31:16], vertex_in[9],
                           vertex_in[10][31:16], vertex_in[11][31:16], vertex_in[14]};

endmodule

// File: doc/rasterizer_triangle_setup.md
Name: rasterizer_triangle_setup

Overview:
- Sits directly downstream of the vertex fetch stage and consumes one 15-word triangle record per transfer.
- For each triangle it computes three edge-function coefficient sets, twice the signed area, and a screen-clamped bounding box.
- It normalises winding to positive area and culls degenerate or fully off-screen triangles.
- It presents one setup record per surviving triangle to the rasterizer traversal stage, with stall backpressure on both sides.

Parameters:
- SCREEN_W, 640, screen width in pixels; valid x range is 0..SCREEN_W-1.
- SCREEN_H, 480, screen height in pixels; valid y range is 0..SCREEN_H-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  triangle record present on vertex_in (upstream output_valid).
- vertex_in  in  32x15  triangle record. Vertex v occupies words 5v..5v+4: x, y, z, color, reserved.
- stall_out  out  1  high = block cannot accept a triangle (drives upstream stall_in).
- done_in  in  1  upstream has delivered all triangles.
- done_out  out  1  all triangles have been processed and emitted.
- stall_in  in  1  downstream cannot accept a record.
- out_valid  out  1  setup record valid.
- edge_a, edge_b, edge_c  out  32x3 each  signed edge coefficients, one set per edge 0..2.
- area2  out  32  twice the triangle area, always >0 when out_valid.
- bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y  out  16 each  clamped inclusive bounding box.
- z_out, color_out  out  32x3 each  per-vertex z and color, passed through unchanged.
- cull_count  out  16  number of culled triangles since reset; wraps at 16 bits.

Behaviour:
- Reset (synchronous, any state, including mid-triangle):
  - state <= IDLE.
  - out_valid, done_out, cull_count <= 0.
  - All record outputs <= 0.
  - stall_out is 0 one cycle after reset deasserts.
  - Any in-flight triangle is discarded.
- Coordinates: x and y are the low 16 bits of words 5v and 5v+1, interpreted as signed. Inputs are constrained to ±16383 so all products fit in 32 bits with no overflow handling.
- States and transitions: IDLE, EDGE0, EDGE1, EDGE2, FINAL, OUT.
  - IDLE: stall_out=0. On a posedge with in_valid=1, capture x/y/z/color of all three vertices and go to EDGE0. Otherwise stay in IDLE.
  - stall_out=1 in every state except IDLE. in_valid is ignored whenever stall_out=1.
  - EDGEi (i = 0..2), with j=(i+1)%3:
    - A_i = y_i - y_j; B_i = x_j - x_i (sign-extended to 32 bits).
    - C_i = x_i*y_j - x_j*y_i.
    - One edge per cycle; one signed 16x16 multiplier pair is sufficient.
  - Bounding box min/max of the raw x and y values is accumulated during EDGE0..EDGE2.
  - FINAL:
    - area2 = C0 + C1 + C2.
    - If area2 < 0: negate all A, B, C and area2.
    - If area2 == 0: cull.
    - If raw max_x < 0, raw min_x > SCREEN_W-1, raw max_y < 0, or raw min_y > SCREEN_H-1: cull.
    - Otherwise clamp the box to [0, SCREEN_W-1] x [0, SCREEN_H-1].
    - Cull: cull_count++ and go to IDLE; out_valid stays 0.
    - Not culled: register the outputs, out_valid <= 1, go to OUT.
  - OUT: outputs are held stable while stall_in=1. A transfer occurs on a posedge with out_valid=1 and stall_in=0; on that edge out_valid <= 0 and the state goes to IDLE.
- Latency and throughput:
  - A triangle accepted at posedge N has out_valid high from posedge N+4 (5th edge counting the accept edge).
  - Peak throughput is one triangle per 6 cycles: accept, EDGE0, EDGE1, EDGE2, FINAL, OUT.
  - A culled triangle frees the block after 4 cycles.
- done_out: registered.
  - Set to 1 when done_in=1, the state is IDLE, and in_valid=0.
  - Cleared when done_in=0.
  - It must never assert while a triangle is in flight.
- Simultaneous events: in_valid arriving while in OUT with stall_in=0 is not accepted in that cycle, because stall_out=1. Upstream holds the record.

Test Plan:
- Vertices (0,0), (10,0), (0,10) -> A = {0,-10,10}, B = {10,-10,0}, C = {0,100,0}, area2 = 100, bbox (0,0)-(10,10). out_valid appears 4 cycles after accept; z/color pass through.
- Same triangle with vertices ordered (0,0), (0,10), (10,0) -> raw area2 = -100; output area2 = 100 with every coefficient negated relative to the raw values.
- Collinear vertices (0,0), (5,5), (10,10) -> no out_valid, cull_count 0 -> 1, stall_out low 4 cycles after accept.
- Vertices (-20,-20), (700,10), (10,500) -> bbox (0,0)-(639,479). Vertices (700,0), (800,0), (700,100) -> culled.
- Hold stall_in=1 for 3 cycles during OUT -> outputs stable, stall_out=1, a second in_valid is ignored. After release: one transfer, state IDLE, the next triangle is accepted.
- Assert reset while in EDGE1 -> next cycle out_valid=0, cull_count=0, stall_out=0. Assert done_in with the block idle -> done_out=1 on the next edge.
